// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB writeback vs. queued long-latency writes.
// Optional macro WBARB_BYPASS_EN: write an external request the same cycle when the port is idle.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int QDEPTH       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        ext_req,
    input  logic [4:0]  ext_rd,
    input  logic [31:0] ext_data,
    output logic        ext_ack,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs_pending,
    output logic        rf_we,
    output logic [4:0]  rf_dst_addr,
    output logic [31:0] rf_dst,
    output logic        stall_pipe
);

    localparam int CW = $clog2(QDEPTH + 1);

    // Queue is kept as a shift register: entry 0 is always the head.
    logic [4:0]    q_rd_q   [QDEPTH];
    logic [4:0]    q_rd_d   [QDEPTH];
    logic [31:0]   q_data_q [QDEPTH];
    logic [31:0]   q_data_d [QDEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    starve_q, starve_d;

    logic          q_empty, q_full, pipe_valid, ext_acc;
    logic          grant_q, grant_p, bypass, enq;
    logic [CW-1:0] wr_idx;

    always_comb begin
        q_empty    = (count_q == '0);
        q_full     = (count_q == CW'(QDEPTH));
        pipe_valid = pipe_we && (pipe_rd != 5'd0) && !rst;
        ext_ack    = !q_full;
        // x0 requests are acknowledged but never stored or written.
        ext_acc    = ext_req && ext_ack && !rst && (ext_rd != 5'd0);
        grant_q    = !rst && !q_empty && (!pipe_valid || starve_q == 4'(STARVE_LIMIT));
        grant_p    = pipe_valid && !grant_q;
`ifdef WBARB_BYPASS_EN
        bypass     = ext_acc && q_empty && !pipe_valid;
`else
        bypass     = 1'b0;
`endif
        enq        = ext_acc && !bypass;
        stall_pipe = grant_q && pipe_valid;

        rf_we       = 1'b0;
        rf_dst_addr = 5'd0;
        rf_dst      = 32'd0;
        if (grant_q) begin
            rf_we       = 1'b1;
            rf_dst_addr = q_rd_q[0];
            rf_dst      = q_data_q[0];
        end else if (grant_p) begin
            rf_we       = 1'b1;
            rf_dst_addr = pipe_rd;
            rf_dst      = pipe_data;
        end else if (bypass) begin
            rf_we       = 1'b1;
            rf_dst_addr = ext_rd;
            rf_dst      = ext_data;
        end

        for (int i = 0; i < QDEPTH; i++) begin
            q_rd_d[i]   = q_rd_q[i];
            q_data_d[i] = q_data_q[i];
        end
        if (grant_q) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                q_rd_d[i]   = q_rd_q[i+1];
                q_data_d[i] = q_data_q[i+1];
            end
        end
        wr_idx = grant_q ? (count_q - CW'(1)) : count_q;
        for (int i = 0; i < QDEPTH; i++) begin
            if (enq && (i == int'(wr_idx))) begin
                q_rd_d[i]   = ext_rd;
                q_data_d[i] = ext_data;
            end
        end

        count_d = count_q;
        if (enq && !grant_q)      count_d = count_q + CW'(1);
        else if (!enq && grant_q) count_d = count_q - CW'(1);

        // A pipe grant with a non-empty queue implies starve_q < STARVE_LIMIT, so no overflow.
        starve_d = starve_q;
        if (q_empty || grant_q) starve_d = 4'd0;
        else if (grant_p)       starve_d = starve_q + 4'd1;

        rs_pending = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (i < int'(count_q)) begin
                if ((rs1_addr != 5'd0 && rs1_addr == q_rd_q[i]) ||
                    (rs2_addr != 5'd0 && rs2_addr == q_rd_q[i]))
                    rs_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            starve_q <= 4'd0;
        end else begin
            count_q  <= count_d;
            starve_q <= starve_d;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            q_rd_q[i]   <= q_rd_d[i];
            q_data_q[i] <= q_data_d[i];
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default STARVE_LIMIT = 4, QDEPTH = 2).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        ext_req;
    logic [4:0]  ext_rd;
    logic [31:0] ext_data;
    logic        ext_ack;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs_pending;
    logic        rf_we;
    logic [4:0]  rf_dst_addr;
    logic [31:0] rf_dst;
    logic        stall_pipe;

    int n_checks = 0;
    int n_pass   = 0;

    wb_port_arbiter dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .ext_req(ext_req), .ext_rd(ext_rd), .ext_data(ext_data), .ext_ack(ext_ack),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs_pending(rs_pending),
        .rf_we(rf_we), .rf_dst_addr(rf_dst_addr), .rf_dst(rf_dst),
        .stall_pipe(stall_pipe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic drive(input logic r, input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                         input logic ereq, input logic [4:0] erd, input logic [31:0] ed);
        @(negedge clk);
        rst = r; pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
        ext_req = ereq; ext_rd = erd; ext_data = ed;
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic st);
        check({tag, "_we"}, 32'(rf_we), 32'(we));
        if (we) begin
            check({tag, "_addr"}, 32'(rf_dst_addr), 32'(a));
            check({tag, "_data"}, rf_dst, d);
        end
        check({tag, "_stall"}, 32'(stall_pipe), 32'(st));
    endtask

    initial begin
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_ack", 32'(ext_ack), 1);
        check("rst_pend", 32'(rs_pending), 0);
        check_wr("rst", 0, 0, 0, 0);

        // Single external request on an idle pipe.
        drive(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        check("single_ack", 32'(ext_ack), 1);
`ifdef WBARB_BYPASS_EN
        check_wr("single_byp", 1, 5'd5, 32'hDEADBEEF, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("single_after", 0, 0, 0, 0);
`else
        check_wr("single_c0", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("single_c1", 1, 5'd5, 32'hDEADBEEF, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("single_c2", 0, 0, 0, 0);
`endif

        // Starvation: queue one write to x7 while the pipe writes x3 every cycle.
        drive(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
        check("starve_ack", 32'(ext_ack), 1);
        check_wr("starve_enq", 1, 5'd3, 32'h33, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 5'd3, 32'h33, 0, 0, 0);
            check_wr($sformatf("starve_pipe%0d", i), 1, 5'd3, 32'h33, 0);
        end
        drive(0, 1, 5'd3, 32'h33, 0, 0, 0);
        check_wr("starve_ext", 1, 5'd7, 32'h77, 1);
        drive(0, 1, 5'd3, 32'h33, 0, 0, 0);
        check_wr("starve_resume", 1, 5'd3, 32'h33, 0);

        // Full queue: three back-to-back requests behind a busy pipe.
        drive(0, 1, 5'd3, 32'h33, 1, 5'd10, 32'hA1);
        check("full_ack_a", 32'(ext_ack), 1);
        drive(0, 1, 5'd3, 32'h33, 1, 5'd11, 32'hA2);
        check("full_ack_b", 32'(ext_ack), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hA3);
            check($sformatf("full_ack_c%0d", i), 32'(ext_ack), 0);
            check_wr($sformatf("full_pipe%0d", i), 1, 5'd3, 32'h33, 0);
        end
        drive(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hA3);
        check("full_ack_drain", 32'(ext_ack), 0);
        check_wr("full_drain_a", 1, 5'd10, 32'hA1, 1);
        drive(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hA3);
        check("full_ack_c_ok", 32'(ext_ack), 1);
        check_wr("full_pipe_after", 1, 5'd3, 32'h33, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("full_drain_b", 1, 5'd11, 32'hA2, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("full_drain_c", 1, 5'd12, 32'hA3, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("full_idle", 0, 0, 0, 0);

        // Pending hazard on a queued write to x9.
        rs2_addr = 5'd9;
        drive(0, 1, 5'd3, 32'h33, 1, 5'd9, 32'h99);
        check("pend_enq_cycle", 32'(rs_pending), 0);
        drive(0, 1, 5'd3, 32'h33, 0, 0, 0);
        check("pend_rs2", 32'(rs_pending), 1);
        rs2_addr = 5'd0; rs1_addr = 5'd9; #1;
        check("pend_rs1", 32'(rs_pending), 1);
        rs1_addr = 5'd0; #1;
        check("pend_zero", 32'(rs_pending), 0);
        rs2_addr = 5'd9;
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("pend_write", 1, 5'd9, 32'h99, 0);
        check("pend_during_write", 32'(rs_pending), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("pend_drop", 32'(rs_pending), 0);
        rs2_addr = 5'd0;

        // Reset with two entries queued.
        drive(0, 1, 5'd3, 32'h33, 1, 5'd20, 32'hB0);
        drive(0, 1, 5'd3, 32'h33, 1, 5'd21, 32'hB1);
        check("rq_full", 32'(ext_ack), 1);
        drive(1, 1, 5'd3, 32'h33, 1, 5'd22, 32'hB2);
        check_wr("rq_in_rst", 0, 0, 0, 0);
        rs1_addr = 5'd20; rs2_addr = 5'd21;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rq_ack", 32'(ext_ack), 1);
        check("rq_pend", 32'(rs_pending), 0);
        check_wr("rq_c1", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("rq_c2", 0, 0, 0, 0);
        rs1_addr = 5'd0; rs2_addr = 5'd0;

        // x0 writes from both sources.
        drive(0, 1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
        check("x0_ack", 32'(ext_ack), 1);
        check_wr("x0_c0", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_wr("x0_c1", 0, 0, 0, 0);
        check("x0_ack_after", 32'(ext_ack), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the maximum consecutive pipeline grants while an external write waits (legal range 1-15).
REQ-002 SHALL have parameter QDEPTH, default 2, the number of external-write queue entries (legal values 2 or 4).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pipe_we  in  1  MEM/WB writeback valid.
REQ-006 pipe_rd  in  5  MEM/WB destination register.
REQ-007 pipe_data  in  32  MEM/WB writeback data.
REQ-008 ext_req  in  1  long-latency unit write request.
REQ-009 ext_rd  in  5  external destination register.
REQ-010 ext_data  in  32  external write data.
REQ-011 ext_ack  out  1  request accepted this cycle.
REQ-012 rs1_addr, rs2_addr  in  5 each  decode-stage source registers.
REQ-013 rs_pending  out  1  a source register has a queued external write.
REQ-014 rf_we, rf_dst_addr, rf_dst  out  1/5/32  register-file write port.
REQ-015 stall_pipe  out  1  pipeline must hold MEM/WB this cycle.

Function
REQ-016 SHALL treat a write to x0 (rd = 0) as no write; such a pipe write never asserts rf_we.
REQ-017 SHALL treat an external write to x0 as accepted and discarded; it never occupies the queue.
REQ-018 SHALL hold external writes in a FIFO of QDEPTH entries, each entry {rd, data}, drained in arrival order.
REQ-019 SHALL drive ext_ack = not full (combinational); acceptance = ext_req & ext_ack.
REQ-020 SHALL keep ext_ack low when the queue is full, even if a dequeue occurs the same cycle.
REQ-021 SHALL decide the grant each cycle as follows:
- queue empty -> pipeline;
- queue non-empty and pipeline has no valid write -> queue head;
- otherwise pipeline, unless starve count = STARVE_LIMIT, in which case queue head.
REQ-022 SHALL increment the starve count on each cycle the pipeline is granted while the queue is non-empty.
REQ-023 SHALL clear the starve count on any queue-head grant or whenever the queue is empty.
REQ-024 SHALL assert stall_pipe exactly in cycles where the queue head is granted and the pipeline has a valid write; the pipeline re-presents the same write next cycle.
REQ-025 SHALL drive rf_we/rf_dst_addr/rf_dst combinationally from the granted source; rf_we = 0 when nothing is granted.
REQ-026 SHALL assert rs_pending when a non-zero rs1_addr or rs2_addr equals the rd of any valid queue entry.
REQ-027 SHALL write an accepted external request no earlier than the cycle after acceptance (without REQ-032).
REQ-028 SHALL NOT cancel or merge queued entries on a matching pipeline rd; WAW ordering between sources is software's responsibility.
REQ-029 SHALL keep simultaneous enqueue and dequeue on a non-full queue consistent: occupancy is unchanged and the FIFO order is preserved.

Reset
REQ-030 SHALL, on rst, empty the queue, clear the starve count, and drive rf_we = 0, stall_pipe = 0, rs_pending = 0, ext_ack = 1 in the following cycle; in-flight queued writes are lost.
REQ-031 SHALL ignore ext_req and pipe_we during the cycle in which rst is asserted.

Configuration
REQ-032 With WBARB_BYPASS_EN defined, an external request arriving when the queue is empty and no valid pipe write is present SHALL be written the same cycle, bypassing the queue; without the macro it SHALL be enqueued and written at the earliest the next cycle.

Verification
REQ-033 Single request: ext_req with rd = 5, data = 0xDEADBEEF on an idle pipe -> ext_ack = 1; next cycle rf_we = 1, rf_dst_addr = 5, rf_dst = 0xDEADBEEF (same cycle with WBARB_BYPASS_EN).
REQ-034 Starvation: pipe_we = 1 continuously with rd = 3 and one queued external write to rd = 7 -> pipeline granted 4 cycles, then rd = 7 written with stall_pipe = 1 in that cycle, then rd = 3 resumes.
REQ-035 Full queue: 3 back-to-back ext_req while pipe is busy (QDEPTH = 2) -> third request sees ext_ack = 0 until the first drain; data is written in order.
REQ-036 Pending hazard: queued write to rd = 9 with rs2_addr = 9 -> rs_pending = 1; rs_pending drops the cycle after rd = 9 is written; rs1_addr = 0 never sets it.
REQ-037 Reset with 2 entries queued: rst for one cycle -> no further rf_we for those entries; ext_ack = 1 and rs_pending = 0 next cycle.
REQ-038 x0 writes: pipe_rd = 0 and ext_rd = 0 requests -> rf_we stays 0; ext_ack = 1; queue occupancy unchanged.
